// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, ALU/MDU operation enums, forwarding selects
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_MFHI, ALU_MFLO, ALU_ZERO
    } alu_op_t;

    typedef enum logic [1:0] {
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
    } mdu_op_t;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// rtl/ex_stage_mdu_if.sv - ID/EX operand bundle and EX/MEM result bundle
interface ex_stage_mdu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] fwd_mem;
    logic [WIDTH-1:0] fwd_wb;
    logic [1:0]       rs_sel;
    logic [1:0]       rt_sel;
    logic [WIDTH-1:0] imm;
    logic [5:0]       opcode;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             mdu_busy;
    logic             mdu_done;

    modport master (
        output in_valid, flush, rs_data, rt_data, fwd_mem, fwd_wb,
               rs_sel, rt_sel, imm, opcode,
        input  in_ready, out_valid, result, store_data, hi, lo, mdu_busy, mdu_done
    );

    modport slave (
        input  in_valid, flush, rs_data, rt_data, fwd_mem, fwd_wb,
               rs_sel, rt_sel, imm, opcode,
        output in_ready, out_valid, result, store_data, hi, lo, mdu_busy, mdu_done
    );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative shift-add multiplier / restoring divider with HI/LO
module mdu_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] dividend;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   mul_sum, trial, diff;
    logic             fits;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    // Operand magnitudes captured at start; signs are reapplied on the last step
    always_comb begin
        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        mag_a_in  = a_neg ? -a : a;
        mag_b_in  = b_neg ? -b : b;
    end

    // One iteration: multiply shifts the product right, divide shifts the remainder left
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        trial   = {acc_hi, acc_lo[WIDTH-1]};
        diff    = trial - {1'b0, mag_b};
        fits    = !diff[WIDTH];
        if (is_div) begin
            step_hi = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = {step_hi, step_lo};
        if (!is_div) begin
            prod   = neg_lo ? -prod : prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            fin_hi = dividend;
            fin_lo = '1;
        end else begin
            fin_hi = neg_hi ? -step_hi : step_hi;
            fin_lo = neg_lo ? -step_lo : step_lo;
        end
    end

    // Control FSM: IDLE -> RUN (WIDTH steps) -> DONE, abortable while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            dividend <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count - 1'b1;
                        if (count == '0) begin
                            hi    <= fin_hi;
                            lo    <= fin_lo;
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        count    <= CW'(WIDTH - 1);
                        is_div   <= (op == MDU_DIV) || (op == MDU_DIVU);
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= (b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= mag_a_in;
                        mag_b    <= mag_b_in;
                        dividend <= a;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - MIPS execute stage: forwarding, decode, ALU, EX/MEM register, MDU
module ex_stage_mdu
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_stage_mdu_if.slave  bus
);
    logic [WIDTH-1:0]      op_a, rt_val, op_b, alu_res, mdu_hi, mdu_lo;
    logic [5:0]            funct;
    logic [SHAMT_BITS-1:0] shamt;
    alu_op_t               alu_op;
    mdu_op_t               mdu_op;
    logic                  use_imm, zext_imm, writes_gpr, is_mdu;
    logic                  accept, busy, done;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      result_q, store_q;

    assign funct  = bus.imm[5:0];
    assign shamt  = bus.imm[SHAMT_BITS+5:6];
    assign accept = bus.in_valid & !busy & !bus.flush;

    // Operand forwarding from MEM / WB, register value otherwise
    always_comb begin
        case (bus.rs_sel)
            FWD_MEM: op_a = bus.fwd_mem;
            FWD_WB:  op_a = bus.fwd_wb;
            default: op_a = bus.rs_data;
        endcase
        case (bus.rt_sel)
            FWD_MEM: rt_val = bus.fwd_mem;
            FWD_WB:  rt_val = bus.fwd_wb;
            default: rt_val = bus.rt_data;
        endcase
        op_b = use_imm ? (zext_imm ? {{(WIDTH-16){1'b0}}, bus.imm[15:0]} : bus.imm) : rt_val;
    end

    // Decode opcode/funct into ALU operation, operand source and MDU request
    always_comb begin
        alu_op     = ALU_ZERO;
        mdu_op     = MDU_MULT;
        use_imm    = 1'b0;
        zext_imm   = 1'b0;
        writes_gpr = 1'b1;
        is_mdu     = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:   alu_op = ALU_ADD;
                    FN_SUB:   alu_op = ALU_SUB;
                    FN_AND:   alu_op = ALU_AND;
                    FN_OR:    alu_op = ALU_OR;
                    FN_XOR:   alu_op = ALU_XOR;
                    FN_NOR:   alu_op = ALU_NOR;
                    FN_SLT:   alu_op = ALU_SLT;
                    FN_SLL:   alu_op = ALU_SLL;
                    FN_SRL:   alu_op = ALU_SRL;
                    FN_MFHI:  alu_op = ALU_MFHI;
                    FN_MFLO:  alu_op = ALU_MFLO;
                    FN_MULT:  begin is_mdu = 1'b1; writes_gpr = 1'b0; mdu_op = MDU_MULT;  end
                    FN_MULTU: begin is_mdu = 1'b1; writes_gpr = 1'b0; mdu_op = MDU_MULTU; end
                    FN_DIV:   begin is_mdu = 1'b1; writes_gpr = 1'b0; mdu_op = MDU_DIV;   end
                    FN_DIVU:  begin is_mdu = 1'b1; writes_gpr = 1'b0; mdu_op = MDU_DIVU;  end
                    default:  alu_op = ALU_ZERO;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; end
            OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; zext_imm = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; zext_imm = 1'b1; end
            OP_LW:   begin alu_op = ALU_ADD; use_imm = 1'b1; end
            OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; writes_gpr = 1'b0; end
            default: alu_op = ALU_ZERO;
        endcase
    end

    // Single-cycle ALU; shifts operate on the forwarded RT value
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL:  alu_res = rt_val << shamt;
            ALU_SRL:  alu_res = rt_val >> shamt;
            ALU_MFHI: alu_res = mdu_hi;
            ALU_MFLO: alu_res = mdu_lo;
            default:  alu_res = '0;
        endcase
    end

    // EX/MEM register; MDU ops leave result/store_data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
        end else begin
            out_valid_q <= accept & writes_gpr;
            if (accept && !is_mdu) begin
                result_q <= alu_res;
                store_q  <= rt_val;
            end
        end
    end

    mdu_seq #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept & is_mdu),
        .abort (bus.flush),
        .op    (mdu_op),
        .a     (op_a),
        .b     (rt_val),
        .busy  (busy),
        .done  (done),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    assign bus.in_ready   = !busy;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.store_data = store_q;
    assign bus.hi         = mdu_hi;
    assign bus.lo         = mdu_lo;
    assign bus.mdu_busy   = busy;
    assign bus.mdu_done   = done;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - randomized bench with behavioural reference model for ex_stage_mdu
module tb_ex_stage_mdu;
    localparam int W = 32;

    bit   clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_stage_mdu_if #(.WIDTH(W)) bus ();

    ex_stage_mdu #(.WIDTH(W), .SHAMT_BITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (s == 2'b01) return m;
        if (s == 2'b10) return w;
        return r;
    endfunction

    // Architectural meaning of one instruction
    function automatic void ref_exec(input logic [5:0] opc, input logic [31:0] immv,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] h, input logic [31:0] l,
                                     output bit mdu, output bit wr, output logic [31:0] res);
        int sa, sb, si;
        sa = a; sb = b; si = immv;
        mdu = 0; wr = 1; res = 0;
        if (opc == 6'h00) begin
            case (immv[5:0])
                6'h20: res = a + b;
                6'h22: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
                6'h00: res = b << immv[10:6];
                6'h02: res = b >> immv[10:6];
                6'h10: res = h;
                6'h12: res = l;
                6'h18, 6'h19, 6'h1A, 6'h1B: begin mdu = 1; wr = 0; end
                default: res = 0;
            endcase
        end else begin
            case (opc)
                6'h08: res = a + immv;
                6'h0A: res = (sa < si) ? 32'd1 : 32'd0;
                6'h0C: res = a & {16'h0, immv[15:0]};
                6'h0D: res = a | {16'h0, immv[15:0]};
                6'h23: res = a + immv;
                6'h2B: begin res = a + immv; wr = 0; end
                default: res = 0;
            endcase
        end
    endfunction

    function automatic void ref_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        int sa, sb;
        longint p;
        logic [63:0] pu;
        sa = a; sb = b;
        h = 0; l = 0;
        case (fn)
            6'h18: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
            6'h19: begin pu = {32'h0, a} * {32'h0, b}; h = pu[63:32]; l = pu[31:0]; end
            6'h1A: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
                else begin l = sa / sb; h = sa % sb; end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    logic        m_valid, m_done;
    logic [31:0] m_result, m_store, m_hi, m_lo, m_phi, m_plo;
    int          m_remain;

    // Reference model: an MDU op accepted occupies the unit for W cycles, then HI/LO land
    always @(posedge clk or negedge rst_n) begin : model
        bit acc, mdu, wr;
        logic [31:0] a, b, res, ph, pl;
        if (!rst_n) begin
            m_valid <= 0; m_done <= 0; m_result <= 0; m_store <= 0;
            m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0; m_remain <= 0;
        end else begin
            acc = bus.in_valid && (m_remain == 0) && !bus.flush;
            a = pick(bus.rs_sel, bus.rs_data, bus.fwd_mem, bus.fwd_wb);
            b = pick(bus.rt_sel, bus.rt_data, bus.fwd_mem, bus.fwd_wb);
            m_done  <= 0;
            m_valid <= 0;
            if (m_remain > 0) begin
                if (bus.flush) m_remain <= 0;
                else if (m_remain == 1) begin
                    m_remain <= 0; m_hi <= m_phi; m_lo <= m_plo; m_done <= 1;
                end else m_remain <= m_remain - 1;
            end
            if (acc) begin
                ref_exec(bus.opcode, bus.imm, a, b, m_hi, m_lo, mdu, wr, res);
                if (mdu) begin
                    ref_mdu(bus.imm[5:0], a, b, ph, pl);
                    m_phi <= ph; m_plo <= pl; m_remain <= W;
                end else begin
                    m_valid <= wr; m_result <= res; m_store <= b;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid",  {31'b0, bus.out_valid}, {31'b0, m_valid});
            chk("result",     bus.result, m_result);
            chk("store_data", bus.store_data, m_store);
            chk("hi",         bus.hi, m_hi);
            chk("lo",         bus.lo, m_lo);
            chk("mdu_busy",   {31'b0, bus.mdu_busy}, {31'b0, m_remain != 0});
            chk("in_ready",   {31'b0, bus.in_ready}, {31'b0, m_remain == 0});
            chk("mdu_done",   {31'b0, bus.mdu_done}, {31'b0, m_done});
        end
    end

    task automatic drive(input bit v, input logic [5:0] opc, input logic [31:0] immv,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [1:0] rss, input logic [1:0] rts,
                         input logic [31:0] fm, input logic [31:0] fw, input bit fl);
        bus.in_valid = v;  bus.opcode = opc; bus.imm = immv;
        bus.rs_data = rs;  bus.rt_data = rt; bus.rs_sel = rss; bus.rt_sel = rts;
        bus.fwd_mem = fm;  bus.fwd_wb = fw;  bus.flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 6'h00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    endtask

    task automatic rop(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
        drive(1, 6'h00, {26'h0, fn}, rs, rt, 2'b00, 2'b00, 0, 0, 0);
    endtask

    task automatic wait_mdu(output int cnt);
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 200) begin
            idle();
            cnt++;
        end
        if (cnt >= 200) chk("mdu_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        logic [5:0] rfn [16] = '{6'h00, 6'h02, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
        logic [5:0] iop [7]  = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3E};
        logic [5:0] opc;
        logic [31:0] immv, r;

        rst_n = 1'b1;
        bus.in_valid = 0; bus.flush = 0; bus.opcode = 0; bus.imm = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.rs_sel = 0; bus.rt_sel = 0;
        bus.fwd_mem = 0; bus.fwd_wb = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_store", bus.store_data, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'b0, bus.mdu_busy}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1, 6'h00, 32'h20, 32'd5, 32'd3, 2'b01, 2'b00, 32'd9, 32'd0, 0);
        chk("fwd_add_result", bus.result, 32'd12);
        chk("fwd_add_valid", {31'b0, bus.out_valid}, 32'd1);
        drive(1, 6'h08, 32'hFFFFFFFF, 32'd1, 0, 2'b00, 2'b00, 0, 0, 0);
        chk("addi_wrap", bus.result, 32'd0);
        drive(1, 6'h0C, 32'hFFFF8000, 32'hFFFFFFFF, 0, 2'b00, 2'b00, 0, 0, 0);
        chk("andi_zext", bus.result, 32'h00008000);

        rop(6'h18, 32'hFFFFFFFD, 32'd7);
        wait_mdu(cnt);
        chk("mult_ready_low_cycles", 32'(cnt), 32'd32);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFEB);
        chk("mult_done", {31'b0, bus.mdu_done}, 32'd1);
        chk("mult_busy_in_done", {31'b0, bus.mdu_busy}, 32'd0);
        rop(6'h12, 0, 0);
        chk("mflo_result", bus.result, 32'hFFFFFFEB);
        chk("done_single_pulse", {31'b0, bus.mdu_done}, 32'd0);

        rop(6'h1A, 32'hFFFFFFF9, 32'd2);
        wait_mdu(cnt);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        rop(6'h1B, 32'd10, 32'd0);
        wait_mdu(cnt);
        chk("divu0_lo", bus.lo, 32'hFFFFFFFF);
        chk("divu0_hi", bus.hi, 32'd10);

        rop(6'h19, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) idle();
        drive(0, 6'h00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        chk("flush_busy_clear", {31'b0, bus.mdu_busy}, 32'd0);
        chk("flush_hi_kept", bus.hi, 32'd10);
        chk("flush_lo_kept", bus.lo, 32'hFFFFFFFF);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mdu_done === 1'b1) seen = 1;
            idle();
        end
        chk("flush_no_done", {31'b0, seen}, 32'd0);

        rop(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        wait_mdu(cnt);
        chk("intmin_lo", bus.lo, 32'h80000000);
        chk("intmin_hi", bus.hi, 32'd0);
        rop(6'h1A, 32'hFFFFFFFB, 32'd0);
        wait_mdu(cnt);
        chk("sdiv0_lo", bus.lo, 32'hFFFFFFFF);
        chk("sdiv0_hi", bus.hi, 32'hFFFFFFFB);

        rop(6'h1A, 32'd100, 32'd7);
        repeat (5) idle();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, bus.mdu_busy}, 32'd0);
        chk("midrst_done", {31'b0, bus.mdu_done}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_store", bus.store_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("postrst_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (3) idle();
        chk("postrst_stays_idle", {31'b0, bus.mdu_busy}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            if (r[0]) begin
                opc  = 6'h00;
                immv = {$urandom, 5'h0, 6'h0};
                immv = {immv[31:6], rfn[$urandom_range(0, 15)]};
            end else begin
                opc  = iop[$urandom_range(0, 6)];
                immv = r[1] ? rnd_val() : {{16{r[17]}}, r[17:2]};
            end
            drive(($urandom_range(0, 3) != 0), opc, immv, rnd_val(), rnd_val(),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  rnd_val(), rnd_val(), ($urandom_range(0, 49) == 0));
        end
        repeat (40) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
